fft_size_factor: RTL and testbench
==================================

# fft_size_factor

Sequential factoriser that decomposes a DFT size N (the PUSCH transform-precoding length, 12 × number of PRBs) into radix-2, radix-3 and radix-5 stage counts. It is the inverse of the stage-to-power calculator: it produces the `stage2`/`stage3`/`stage5` exponents that configure the mixed-radix FFT datapath. It sits between the PUSCH allocation decoder and the FFT controller, and runs once per allocation change.

## Interface

Parameters:
- `N_W`, default 12: width of the size input; supports N ≤ 4095.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a factorisation; sampled only in IDLE.
- `size_n` in `N_W`: DFT size; sampled on an accepted `start`.
- `busy` out 1: high from the cycle after an accepted start through the cycle `done` is high.
- `done` out 1: single-cycle pulse; results are valid from this cycle.
- `error` out 1: valid with `done`; N is not of the form 2^a·3^b·5^c, or an exponent is out of range.
- `stage2` out 4: exponent a.
- `stage3` out 3: exponent b.
- `stage5` out 2: exponent c.

## Operation

- States: IDLE, DIV2, DIV3, DIV5, FIN.
- **IDLE**
  - On `start`, load residue r ← `size_n` and clear the internal counters a, b, c.
  - Counter widths are a: 4 b, b: 3 b, c: 3 b.
  - Next state is DIV2.
- **DIV2**, one factor per cycle:
  - If r ≠ 0 and r[0] = 0: r ← r >> 1 and a++.
  - Otherwise go to DIV3.
- **DIV3**
  - If r ≠ 0 and r mod 3 = 0: r ← r / 3 and b++.
  - Otherwise go to DIV5.
  - Division by the constant is combinational on r; there is no iterative divider.
- **DIV5**
  - If r ≠ 0 and r mod 5 = 0: r ← r / 5 and c++.
  - Otherwise go to FIN.
- **FIN**
  - `error` = (r ≠ 1) | (a < 2) | (a > 8) | (b > 5) | (c > 2).
  - Register the outputs and pulse `done`. The next state is IDLE.
- On error, `stage2`, `stage3` and `stage5` are forced to 0.
- Outputs hold their last values until the next FIN.
- `start` while `busy` is ignored; there is no queueing.
- N = 0 skips all divisions. r = 0 ≠ 1, so `error` is set.
- Counters cannot overflow for N ≤ 4095 (a ≤ 11, b ≤ 7, c ≤ 5).

## Timing

- `start` is sampled at edge 0. `done` is high in cycle a+b+c+4 after that edge.
  - 1 cycle for the load.
  - Each prime costs its exponent plus one exit cycle.
- Minimum latency is 4 (N = 0 or N = 1).
- `busy` rises the cycle after the accepting edge and falls together with the end of `done`.
- A new `start` may be accepted in the cycle immediately after `done`.
- Reset values: `busy`, `done` and `error` = 0; `stage2`, `stage3`, `stage5` = 0; the FSM is in IDLE; r and the counters are 0.
- Reset mid-operation aborts immediately with no `done`. The outputs return to their reset values.

## Configuration

- Macro `FFT_FACTOR_POW_OUT_EN`.
- **Defined:** extra outputs `pow2` (out, 9 b) and `pow3x5` (out, 8 b).
  - They are registered in FIN together with the stage outputs.
  - They are computed from the final exponents by the sub-module.
  - `pow3x5` = 3^b·5^c, and equals 3^b when c = 0.
  - Both are 0 on error.
  - Both reset to 0.
- **Undefined:** these ports and the sub-module are absent. Stage-output behaviour is identical.

## Structure

- Package `fft_pkg` holds:
  - The FSM state enum.
  - Stage widths (4/3/2).
  - Exponent limits `STAGE2_MIN` = 2, `STAGE2_MAX` = 8, `STAGE3_MAX` = 5, `STAGE5_MAX` = 2.
  - The power output widths.
- Sub-module `fft_pow_lut` (combinational exponent → power lookup) is instantiated only under `FFT_FACTOR_POW_OUT_EN`.

## Test plan

- N = 12 → `stage2` = 2, `stage3` = 1, `stage5` = 0, `error` = 0, `done` at cycle 7. With the macro, `pow2` = 4 and `pow3x5` = 3.
- N = 1200 → 4/1/2, `error` = 0, `done` at cycle 11. With the macro, `pow2` = 16 and `pow3x5` = 75.
- N = 14 → `error` = 1 (residue 7) and stages = 0. N = 0 → `error` = 1 with `done` at cycle 4.
- N = 3072 (2^10·3) → `error` = 1 because a > 8. N = 6 → `error` = 1 because a < 2.
- `start` with N = 48 issued during a busy N = 1200 run → ignored. The 1200 result is reported once, and the next `start` is accepted the cycle after `done`.
- `rst_n` low in the middle of DIV3 → no `done` pulse and all outputs 0. A `start` with N = 12 after release → normal result at cycle 7.

Source files
------------

// File: rtl/fft_size_factor_pkg.sv
// Shared types and limits for the DFT-size factoriser (2^a * 3^b * 5^c).
// The power outputs exist only when FFT_FACTOR_POW_OUT_EN is defined.
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV2 = 3'd1,
    ST_DIV3 = 3'd2,
    ST_DIV5 = 3'd3,
    ST_FIN  = 3'd4
  } fsm_state_e;

  localparam int STAGE2_W = 4;
  localparam int STAGE3_W = 3;
  localparam int STAGE5_W = 2;

  // Internal counters are wide enough for any N <= 4095, so they never wrap.
  localparam int CNT2_W = 4;
  localparam int CNT3_W = 3;
  localparam int CNT5_W = 3;

  localparam logic [CNT2_W-1:0] STAGE2_MIN = 4'd2;
  localparam logic [CNT2_W-1:0] STAGE2_MAX = 4'd8;
  localparam logic [CNT3_W-1:0] STAGE3_MAX = 3'd5;
  localparam logic [CNT5_W-1:0] STAGE5_MAX = 3'd2;

  localparam int POW2_W   = 9;
  localparam int POW3X5_W = 8;

endpackage

// File: rtl/fft_size_factor_if.sv
// Request/result bundle of the factoriser; master issues sizes, slave factorises.
// pow2/pow3x5 are present only when FFT_FACTOR_POW_OUT_EN is defined.
interface fft_size_factor_if #(
  parameter int N_W = 12
);
  import fft_pkg::*;

  logic                start;
  logic [N_W-1:0]      size_n;
  logic                busy;
  logic                done;
  logic                error;
  logic [STAGE2_W-1:0] stage2;
  logic [STAGE3_W-1:0] stage3;
  logic [STAGE5_W-1:0] stage5;
`ifdef FFT_FACTOR_POW_OUT_EN
  logic [POW2_W-1:0]   pow2;
  logic [POW3X5_W-1:0] pow3x5;
`endif

  modport master (
    output start, size_n,
    input  busy, done, error, stage2, stage3, stage5
`ifdef FFT_FACTOR_POW_OUT_EN
    , input pow2, pow3x5
`endif
  );

  modport slave (
    input  start, size_n,
    output busy, done, error, stage2, stage3, stage5
`ifdef FFT_FACTOR_POW_OUT_EN
    , output pow2, pow3x5
`endif
  );

endinterface

// File: rtl/fft_size_factor_pow_lut.sv
// Combinational exponent-to-power lookup: 2^a and 3^b * 5^c (truncated to the port width).
// Instantiated by fft_size_factor only when FFT_FACTOR_POW_OUT_EN is defined.
module fft_pow_lut
  import fft_pkg::*;
(
  input  logic [STAGE2_W-1:0] exp2_i,
  input  logic [STAGE3_W-1:0] exp3_i,
  input  logic [STAGE5_W-1:0] exp5_i,
  output logic [POW2_W-1:0]   pow2_o,
  output logic [POW3X5_W-1:0] pow3x5_o
);

  logic [POW3X5_W-1:0] p3;
  logic [POW3X5_W-1:0] p5;

  always_comb begin
    p3 = '0;
    p5 = '0;
    case (exp3_i)
      3'd0:    p3 = 8'd1;
      3'd1:    p3 = 8'd3;
      3'd2:    p3 = 8'd9;
      3'd3:    p3 = 8'd27;
      3'd4:    p3 = 8'd81;
      3'd5:    p3 = 8'd243;
      default: p3 = '0;
    endcase
    case (exp5_i)
      2'd0:    p5 = 8'd1;
      2'd1:    p5 = 8'd5;
      2'd2:    p5 = 8'd25;
      default: p5 = '0;
    endcase
  end

  assign pow2_o   = POW2_W'(1) << exp2_i;
  assign pow3x5_o = p3 * p5;

endmodule

// File: rtl/fft_size_factor.sv
// Sequential factoriser: strips 2s, then 3s, then 5s from N, one factor per cycle.
// Optional pow2/pow3x5 outputs are enabled by defining FFT_FACTOR_POW_OUT_EN.
module fft_size_factor #(
  parameter int N_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_size_factor_if.slave   bus
);
  import fft_pkg::*;

  fsm_state_e          state_q, state_d;
  logic [N_W-1:0]      r_q, r_d;
  logic [CNT2_W-1:0]   a_q, a_d;
  logic [CNT3_W-1:0]   b_q, b_d;
  logic [CNT5_W-1:0]   c_q, c_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [STAGE2_W-1:0] stage2_q, stage2_d;
  logic [STAGE3_W-1:0] stage3_q, stage3_d;
  logic [STAGE5_W-1:0] stage5_q, stage5_d;

  // Constant-divisor quotient/remainder, evaluated combinationally every cycle.
  logic [N_W-1:0] quot3, rem3, quot5, rem5;
  logic           fin_error;

  assign quot3 = N_W'(r_q / 3);
  assign rem3  = N_W'(r_q % 3);
  assign quot5 = N_W'(r_q / 5);
  assign rem5  = N_W'(r_q % 5);

  assign fin_error = (r_q != N_W'(1)) | (a_q < STAGE2_MIN) | (a_q > STAGE2_MAX)
                   | (b_q > STAGE3_MAX) | (c_q > STAGE5_MAX);

`ifdef FFT_FACTOR_POW_OUT_EN
  logic [POW2_W-1:0]   pow2_q, pow2_d, lut_pow2;
  logic [POW3X5_W-1:0] pow3x5_q, pow3x5_d, lut_pow3x5;

  fft_pow_lut u_pow_lut (
    .exp2_i   (a_q),
    .exp3_i   (b_q),
    .exp5_i   (c_q[STAGE5_W-1:0]),
    .pow2_o   (lut_pow2),
    .pow3x5_o (lut_pow3x5)
  );
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    r_d      = r_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    done_d   = 1'b0;
    error_d  = error_q;
    stage2_d = stage2_q;
    stage3_d = stage3_q;
    stage5_d = stage5_q;
`ifdef FFT_FACTOR_POW_OUT_EN
    pow2_d   = pow2_q;
    pow3x5_d = pow3x5_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          r_d     = bus.size_n;
          a_d     = '0;
          b_d     = '0;
          c_d     = '0;
          state_d = ST_DIV2;
        end
      end
      ST_DIV2: begin
        if (r_q != '0 && !r_q[0]) begin
          r_d = r_q >> 1;
          a_d = a_q + 1'b1;
        end else begin
          state_d = ST_DIV3;
        end
      end
      ST_DIV3: begin
        if (r_q != '0 && rem3 == '0) begin
          r_d = quot3;
          b_d = b_q + 1'b1;
        end else begin
          state_d = ST_DIV5;
        end
      end
      ST_DIV5: begin
        if (r_q != '0 && rem5 == '0) begin
          r_d = quot5;
          c_d = c_q + 1'b1;
        end else begin
          // Results are registered on entry to FIN so they are valid alongside done.
          state_d  = ST_FIN;
          done_d   = 1'b1;
          error_d  = fin_error;
          stage2_d = fin_error ? '0 : a_q;
          stage3_d = fin_error ? '0 : b_q;
          stage5_d = fin_error ? '0 : c_q[STAGE5_W-1:0];
`ifdef FFT_FACTOR_POW_OUT_EN
          pow2_d   = fin_error ? '0 : lut_pow2;
          pow3x5_d = fin_error ? '0 : lut_pow3x5;
`endif
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      stage2_q <= '0;
      stage3_q <= '0;
      stage5_q <= '0;
`ifdef FFT_FACTOR_POW_OUT_EN
      pow2_q   <= '0;
      pow3x5_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      state_q  <= state_d;
      r_q      <= r_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      done_q   <= done_d;
      error_q  <= error_d;
      stage2_q <= stage2_d;
      stage3_q <= stage3_d;
      stage5_q <= stage5_d;
`ifdef FFT_FACTOR_POW_OUT_EN
      pow2_q   <= pow2_d;
      pow3x5_q <= pow3x5_d;
`endif
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.stage2 = stage2_q;
  assign bus.stage3 = stage3_q;
  assign bus.stage5 = stage5_q;
`ifdef FFT_FACTOR_POW_OUT_EN
  assign bus.pow2   = pow2_q;
  assign bus.pow3x5 = pow3x5_q;
`endif

endmodule

// File: tb/tb_fft_size_factor.sv
// Scoreboard bench for fft_size_factor: a driver predicts each accepted request with a
// plain-arithmetic factorisation model; a negedge monitor compares every cycle.
module tb_fft_size_factor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_size_factor_if #(.N_W(12)) bus();

  fft_size_factor #(.N_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int n;
    int err;
    int s2;
    int s3;
    int s5;
    int p2;
    int p35;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  // Model view of the single in-flight run (cycle indices in terms of cyc).
  int   last_done = 0;
  int   busy_from = 1;
  int   busy_to   = 0;
  // Output values the DUT must be holding, owned by the monitor.
  int   h_err = 0, h_s2 = 0, h_s3 = 0, h_s5 = 0, h_p2 = 0, h_p35 = 0;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, want);
    end
  endtask

  // Reference: divide out each prime with ordinary integer arithmetic.
  function automatic exp_t model(input int n);
    exp_t e;
    int   r = n;
    int   a = 0, b = 0, c = 0;
    int   p = 1;
    if (r != 0) begin
      while (r % 2 == 0) begin r = r / 2; a++; end
      while (r % 3 == 0) begin r = r / 3; b++; end
      while (r % 5 == 0) begin r = r / 5; c++; end
    end
    e.n   = n;
    e.err = (r != 1 || a < 2 || a > 8 || b > 5 || c > 2) ? 1 : 0;
    e.s2  = e.err ? 0 : a;
    e.s3  = e.err ? 0 : b;
    e.s5  = e.err ? 0 : c;
    e.p2  = e.err ? 0 : (1 << a);
    for (int i = 0; i < b; i++) p = p * 3;
    for (int i = 0; i < c; i++) p = p * 5;
    e.p35      = e.err ? 0 : (p % 256);
    e.done_cyc = a + b + c + 4;
    return e;
  endfunction

  task automatic step(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  // Presents start for exactly one rising edge; the model decides whether it is accepted.
  task automatic issue(input int n);
    exp_t e;
    bus.start  = 1'b1;
    bus.size_n = 12'(n);
    if (cyc > last_done) begin
      e          = model(n);
      e.done_cyc = e.done_cyc + cyc;
      sb.push_back(e);
      busy_from  = cyc + 1;
      busy_to    = e.done_cyc;
      last_done  = e.done_cyc;
    end
    step(1);
    bus.start  = 1'b0;
    bus.size_n = 12'($urandom);
  endtask

  task automatic wait_idle();
    while (cyc <= last_done) step(1);
  endtask

  task automatic pulse_reset(input int k);
    rst_n     = 1'b0;
    sb.delete();
    busy_from = 1;
    busy_to   = 0;
    step(k);
    rst_n     = 1'b1;
    last_done = cyc - 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   exp_done;
    if (!rst_n) begin
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      h_err = 0; h_s2 = 0; h_s3 = 0; h_s5 = 0; h_p2 = 0; h_p35 = 0;
    end else begin
      check("busy", int'(bus.busy), (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
      exp_done = (sb.size() != 0 && sb[0].done_cyc == cyc) ? 1 : 0;
      check("done", int'(bus.done), exp_done);
      if (exp_done == 1) begin
        e     = sb.pop_front();
        h_err = e.err; h_s2 = e.s2; h_s3 = e.s3; h_s5 = e.s5;
        h_p2  = e.p2;  h_p35 = e.p35;
      end
    end
    check("error",  int'(bus.error),  h_err);
    check("stage2", int'(bus.stage2), h_s2);
    check("stage3", int'(bus.stage3), h_s3);
    check("stage5", int'(bus.stage5), h_s5);
`ifdef FFT_FACTOR_POW_OUT_EN
    check("pow2",   int'(bus.pow2),   h_p2);
    check("pow3x5", int'(bus.pow3x5), h_p35);
`endif
  end

  initial begin
    int directed[6] = '{12, 1200, 14, 0, 3072, 6};
    int n;
    bus.start  = 1'b0;
    bus.size_n = '0;
    pulse_reset(3);

    foreach (directed[i]) begin
      issue(directed[i]);
      wait_idle();
    end

    // Start during a busy run is dropped, also during the done cycle; the next cycle is accepted.
    issue(1200);
    step(3);
    issue(48);
    while (cyc < last_done) step(1);
    issue(48);
    issue(96);
    wait_idle();

    // Reset while the N=12 run is in the radix-3 phase, then a clean rerun.
    issue(12);
    step(3);
    pulse_reset(2);
    issue(12);
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      n = ($urandom_range(0, 1) == 1) ? 12 * $urandom_range(1, 341) : $urandom_range(0, 4095);
      if ($urandom_range(0, 9) < 7) wait_idle();
      step($urandom_range(0, 2));
      issue(n);
    end

    wait_idle();
    step(2);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

endmodule
